// File: rtl/ecc_err_logger_pkg.sv
// ecc_log_pkg: shared error-type encodings and log-entry width helper
package ecc_log_pkg;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SB   = 2'b01;
    localparam logic [1:0] ERR_DB   = 2'b10;

    function automatic int log_w(input int addr_w, input int data_w);
        return 2 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/ecc_err_logger_if.sv
// ecc_err_logger_if: read-path sample inputs and log/status outputs of the error logger
interface ecc_err_logger_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
);
    logic                       R_EN;
    logic [ADDR_W-1:0]          R_ADDR;
    logic [DATA_W-1:0]          real_data;
    logic [DATA_W-1:0]          wrong_real_data;
    logic                       SB_CORRECT;
    logic                       DB_DETECT;
    logic                       LOG_POP;
    logic                       LOG_CLR;
    logic                       LOG_VALID;
    logic [1:0]                 LOG_TYPE;
    logic [ADDR_W-1:0]          LOG_ADDR;
    logic [DATA_W-1:0]          LOG_DATA;
    logic [$clog2(DEPTH):0]     LOG_LEVEL;
    logic [CNT_W-1:0]           SB_COUNT;
    logic [CNT_W-1:0]           DB_COUNT;
    logic                       OVERFLOW;
    logic                       ENC_ERR;

    modport master (
        output R_EN, R_ADDR, real_data, wrong_real_data, SB_CORRECT, DB_DETECT, LOG_POP, LOG_CLR,
        input  LOG_VALID, LOG_TYPE, LOG_ADDR, LOG_DATA, LOG_LEVEL, SB_COUNT, DB_COUNT, OVERFLOW, ENC_ERR
    );

    modport slave (
        input  R_EN, R_ADDR, real_data, wrong_real_data, SB_CORRECT, DB_DETECT, LOG_POP, LOG_CLR,
        output LOG_VALID, LOG_TYPE, LOG_ADDR, LOG_DATA, LOG_LEVEL, SB_COUNT, DB_COUNT, OVERFLOW, ENC_ERR
    );

endinterface

// File: rtl/ecc_err_logger_fifo.sv
// ecc_log_fifo: synchronous first-word-fall-through FIFO with wrap-bit pointers
module ecc_log_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [AW:0]      level,
    output logic             full
);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    // status flags and pointer advance; a full FIFO still accepts a push when a pop frees the slot
    always_comb begin
        valid    = wr_ptr_q != rd_ptr_q;
        full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        level    = wr_ptr_q - rd_ptr_q;
        pop_ok   = pop && valid;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = clr ? '0 : wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = clr ? '0 : rd_ptr_q + {{AW{1'b0}}, pop_ok};
        dout     = valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    end

    // storage write port
    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = din;
    end

    // pointer registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // storage array needs no reset; entries are only visible between the pointers
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ecc_err_logger.sv
// ecc_err_logger: classifies decoded reads, logs errors in a FIFO, keeps counters and sticky flags
module ecc_err_logger
    import ecc_log_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input logic              CLK,
    input logic              RST_N,
    ecc_err_logger_if.slave  bus
);

    localparam int LW = log_w(ADDR_W, DATA_W);

    logic                   is_sb;
    logic                   is_db;
    logic                   is_enc;
    logic [1:0]             err_type;
    logic [DATA_W-1:0]      err_data;
    logic [LW-1:0]          entry;
    logic [LW-1:0]          head;
    logic                   head_valid;
    logic                   fifo_full;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CNT_W-1:0]       sb_cnt_q, sb_cnt_d;
    logic [CNT_W-1:0]       db_cnt_q, db_cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   enc_q, enc_d;

    // decode the flag pair; a corrected error logs the raw word so the flipped bit can be located
    always_comb begin
        is_sb    = bus.R_EN && bus.SB_CORRECT && !bus.DB_DETECT;
        is_db    = bus.R_EN && bus.SB_CORRECT && bus.DB_DETECT;
        is_enc   = bus.R_EN && !bus.SB_CORRECT && bus.DB_DETECT;
        err_type = is_sb ? ERR_SB : is_db ? ERR_DB : ERR_NONE;
        err_data = is_sb ? bus.wrong_real_data : bus.real_data;
        entry    = {err_type, bus.R_ADDR, err_data};
    end

    ecc_log_fifo #(
        .WIDTH (LW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  ((is_sb || is_db) && !bus.LOG_CLR),
        .pop   (bus.LOG_POP && !bus.LOG_CLR),
        .clr   (bus.LOG_CLR),
        .din   (entry),
        .dout  (head),
        .valid (head_valid),
        .level (fifo_level),
        .full  (fifo_full)
    );

    // counters count every event even when the log drops it; clear wins over a same-cycle event
    always_comb begin
        sb_cnt_d = bus.LOG_CLR ? '0 : (is_sb && !(&sb_cnt_q)) ? sb_cnt_q + 1'b1 : sb_cnt_q;
        db_cnt_d = bus.LOG_CLR ? '0 : (is_db && !(&db_cnt_q)) ? db_cnt_q + 1'b1 : db_cnt_q;
        ovf_d    = !bus.LOG_CLR && (ovf_q || ((is_sb || is_db) && fifo_full && !(bus.LOG_POP && head_valid)));
        enc_d    = !bus.LOG_CLR && (enc_q || is_enc);
    end

    // counter and sticky-flag registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sb_cnt_q <= '0;
            db_cnt_q <= '0;
            ovf_q    <= 1'b0;
            enc_q    <= 1'b0;
        end else begin
            sb_cnt_q <= sb_cnt_d;
            db_cnt_q <= db_cnt_d;
            ovf_q    <= ovf_d;
            enc_q    <= enc_d;
        end
    end

    assign bus.LOG_VALID = head_valid;
    assign bus.LOG_TYPE  = head[LW-1 -: 2];
    assign bus.LOG_ADDR  = head[DATA_W +: ADDR_W];
    assign bus.LOG_DATA  = head[DATA_W-1:0];
    assign bus.LOG_LEVEL = fifo_level;
    assign bus.SB_COUNT  = sb_cnt_q;
    assign bus.DB_COUNT  = db_cnt_q;
    assign bus.OVERFLOW  = ovf_q;
    assign bus.ENC_ERR   = enc_q;

endmodule

// File: doc/ecc_err_logger.md
Name: ecc_err_logger

Overview:
Parametrised successor to the ECC error-address capture stage. It samples each ECC-decoded read and classifies it as clean, single-bit (corrected) or multi-bit (uncorrected). For every error it pushes {type, address, data} into a first-word-fall-through log FIFO and keeps saturating SB/DB counters and sticky status flags. It sits after the SECDED decoder on the read path and is drained by the status/debug interface.

Parameters:
ADDR_W, 14, read address width
DATA_W, 64, data word width
DEPTH, 8, log FIFO entries; power of two, at least 2
CNT_W, 16, width of the SB/DB event counters

Ports:
CLK  in  1  clock; all logic is rising-edge
RST_N  in  1  synchronous, active-low reset
R_EN  in  1  read strobe; one read is qualified per cycle while high
R_ADDR  in  ADDR_W  read address
real_data  in  DATA_W  decoder output data (corrected where possible)
wrong_real_data  in  DATA_W  raw word before correction
SB_CORRECT  in  1  decoder error flag
DB_DETECT  in  1  decoder multi-error flag
LOG_POP  in  1  pop the FIFO head
LOG_CLR  in  1  synchronous clear of the log, counters and flags
LOG_VALID  out  1  FIFO not empty; head fields are valid
LOG_TYPE  out  2  head type, per ERR_* encoding
LOG_ADDR  out  ADDR_W  head address
LOG_DATA  out  DATA_W  head data
LOG_LEVEL  out  clog2(DEPTH)+1  current occupancy
SB_COUNT  out  CNT_W  single-error count, saturating
DB_COUNT  out  CNT_W  multi-error count, saturating
OVERFLOW  out  1  sticky; an error was dropped because the FIFO was full
ENC_ERR  out  1  sticky; the illegal flag combination was seen

Behaviour:
- Classification is combinational on the inputs and sampled at the CLK edge when R_EN=1:
  - SB_CORRECT=1, DB_DETECT=0: single-bit error. Type is ERR_SB, logged data is wrong_real_data.
  - SB_CORRECT=1, DB_DETECT=1: multi-bit error. Type is ERR_DB, logged data is real_data.
  - SB_CORRECT=0, DB_DETECT=1: illegal combination. Set ENC_ERR; nothing is logged or counted.
  - Both flags 0: clean read; no action.
- R_EN=0: flags and data are ignored.
- Push: a qualified error is written at the edge. LOG_VALID and the head fields reflect it the following cycle (latency 1).
- Head fields are FWFT and stay stable until popped. When LOG_VALID=0, the head fields read as 0.
- Pop: LOG_POP=1 with LOG_VALID=1 advances the head at the edge. A pop while empty is ignored with no underflow.
- Push and pop in the same cycle:
  - Both are performed; LOG_LEVEL is unchanged.
  - When full, the push is accepted because the pop frees a slot.
  - When empty, the push lands and the pop is ignored; the entry becomes visible next cycle.
- Full with a push and no pop: the entry is dropped and OVERFLOW is set. Counters still increment, because they count events, not logged entries.
- Counters: SB_COUNT/DB_COUNT increment by 1 per qualified event and hold at 2^CNT_W-1.
- Pointers: ADDR bits plus a wrap bit. Full when the addresses are equal and the wrap bits differ.
- LOG_CLR=1:
  - Empties the FIFO and zeroes the counters, OVERFLOW and ENC_ERR at the edge.
  - Takes priority over a same-cycle push or pop; that cycle's event is discarded.
- Reset (RST_N=0 at an edge) gives the same result as LOG_CLR:
  - All outputs read 0, including LOG_VALID=0 and LOG_LEVEL=0.
  - Reset mid-operation discards all entries.
  - The first event is accepted at the first edge with RST_N=1.
- No combinational path from LOG_POP to any output other than through registers.

Decomposition:
- Package ecc_log_pkg holds:
  - the ERR_NONE=2'b00, ERR_SB=2'b01, ERR_DB=2'b10 type constants
  - the log-entry field width helper (2+ADDR_W+DATA_W)
- Sub-module ecc_log_fifo: a generic synchronous FWFT FIFO with parameters WIDTH and DEPTH. Its ports are push, pop, clr, dout, valid, level and full. It uses the same CLK/RST_N.
- Classification, counters and stickies live in ecc_err_logger.

Test Plan:
- Reset, then R_EN=1, SB=1, DB=0, R_ADDR=0x0123, wrong_real_data=0xDEAD_BEEF_0000_0001 -> next cycle LOG_VALID=1, LOG_TYPE=01, LOG_ADDR=0x0123, LOG_DATA=0xDEADBEEF00000001, SB_COUNT=1.
- SB=1, DB=1, R_ADDR=0x3FFF, real_data=0xFFFF_FFFF_FFFF_FFFF -> entry with LOG_TYPE=10, LOG_DATA=all ones, DB_COUNT=1. Then SB=0, DB=1 -> ENC_ERR=1, LOG_LEVEL unchanged, counters unchanged.
- 9 back-to-back SB events with DEPTH=8 and no pops -> LOG_LEVEL=8, OVERFLOW=1, SB_COUNT=9. Popping 8 times returns addresses 0..7 in order, then LOG_VALID=0.
- FIFO full, push and pop in the same cycle -> LOG_LEVEL stays 8 and OVERFLOW stays 0. Empty FIFO, push and pop in the same cycle -> LOG_LEVEL=1.
- CNT_W=4, 20 SB events -> SB_COUNT=15. LOG_CLR together with an event -> all fields 0 and the event is not logged.
- Reset asserted mid-stream with 5 entries logged -> all outputs 0 the next cycle. An event at the first edge after release is logged.
